// File: rtl/sqrt_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin square-root arbiter.
package sqrt_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Ceiling log2, never smaller than 1 so it can size a vector directly.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sqrt_rr_arbiter_rr_pick.sv
// Combinational round-robin select: first valid at or above ptr_i, wrapping.
module sqrt_rr_arbiter_rr_pick
    import sqrt_rr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |valid_i;
        // Scan from the farthest offset down so the nearest one wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_i[(int'(ptr_i) + k) % NREQ])
                idx_o = IDW'((int'(ptr_i) + k) % NREQ);
        end
        gnt_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/sqrt_rr_arbiter.sv
// Shares one iterative sqrt engine among NREQ clients, one operation in flight.
module sqrt_rr_arbiter
    import sqrt_rr_arbiter_pkg::*;
#(
    parameter int N       = 8,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [N/2-1:0]      resp_data,
    output logic [IDW-1:0]      resp_id,
    output logic                resp_err,
    output logic                eng_start,
    output logic [N-1:0]        eng_a,
    input  logic [N/2-1:0]      eng_o,
    input  logic                eng_ready
);

    localparam int M  = N / 2;
    localparam int CW = clog2(TIMEOUT);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [N-1:0]    a_q, a_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    data_q, data_d;
    logic            err_q, err_d;
    logic            rdy_q;
    logic            done;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  win;
    logic            any;

    sqrt_rr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (win),
        .any_o   (any)
    );

    // A ready level left over from an earlier op must not count as completion.
    assign done = eng_ready & ~rdy_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        err_d     = err_q;
        req_ready = '0;
        eng_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    req_ready = gnt;
                    a_d       = req_data[int'(win)*N +: N];
                    id_d      = win;
                    ptr_d     = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_start = 1'b1;
                cnt_d     = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    data_d  = eng_o;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            rdy_q   <= eng_ready;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = data_q;
    assign resp_id    = id_q;
    assign resp_err   = err_q;
    assign eng_a      = a_q;

endmodule
